// File: rtl/spi_pkg.sv
// Shared types and frame layout for the SPI command front end and the
// control-register block it feeds.
package spi_pkg;

  localparam int unsigned FRAME_W  = 32;
  localparam int unsigned CMD_MSB  = 31;
  localparam int unsigned ADDR_MSB = 23;
  localparam int unsigned DATA_MSB = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_frame_slave_if.sv
// SPI pins plus the frame/response handshake towards the control-register block.
interface spi_frame_slave_if #(
  parameter int unsigned FRAME_W = spi_pkg::FRAME_W
);
  logic               spi_sclk;
  logic               spi_cs_n;
  logic               spi_mosi;
  logic               spi_miso;
  logic [FRAME_W-1:0] spi_rx_data;
  logic               spi_rx_done;
  logic [FRAME_W-1:0] spi_tx_data;
  logic               frame_err;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, spi_tx_data,
    output spi_miso, spi_rx_data, spi_rx_done, frame_err
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, spi_tx_data,
    input  spi_miso, spi_rx_data, spi_rx_done, frame_err
  );
endinterface

// File: rtl/spi_frame_slave_sync_edge.sv
// Multi-stage pin synchronizer with a reset level and rise/fall detect pulses.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic dout_o,
  output logic rise_o_c,
  output logic fall_o_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign dout_o   = sync_q[SYNC_STAGES-1];
  assign rise_o_c = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o_c = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave: oversampled pins in, 32-bit command frames out, response
// word shifted back MSB first on MISO.
module spi_frame_slave #(
  parameter int unsigned FRAME_W     = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_frame_slave_if.slave      bus
);
  import spi_pkg::*;

  localparam int unsigned CNT_W = $clog2(FRAME_W) + 1;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_sync;
  logic sclk_sync_unused, cs_sync_unused;
  logic [1:0] mosi_edges_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din_i(bus.spi_sclk),
    .dout_o(sclk_sync_unused), .rise_o_c(sclk_rise), .fall_o_c(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din_i(bus.spi_cs_n),
    .dout_o(cs_sync_unused), .rise_o_c(cs_rise), .fall_o_c(cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din_i(bus.spi_mosi),
    .dout_o(mosi_sync), .rise_o_c(mosi_edges_unused[0]), .fall_o_c(mosi_edges_unused[1])
  );

  spi_state_t          state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]  rx_shift_q, rx_shift_d;
  logic [FRAME_W-1:0]  tx_shift_q, tx_shift_d;
  logic [FRAME_W-1:0]  rx_data_q, rx_data_d;
  logic                rx_done_q, rx_done_d;
  logic                frame_err_q, frame_err_d;
  logic                miso_q, miso_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
    end
  end

  // CS_N rising takes priority over any SCLK edge seen in the same cycle.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = SHIFT;
          tx_shift_d = bus.spi_tx_data;
          bit_cnt_d  = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[FRAME_W-2:0], mosi_sync};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
            rx_data_d = rx_shift_d;
            rx_done_d = 1'b1;
            state_d   = HOLD;
          end
        end else if (sclk_fall) begin
          tx_shift_d = {tx_shift_q[FRAME_W-2:0], 1'b0};
        end
      end
      HOLD: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    miso_d = (state_d == SHIFT) ? tx_shift_d[FRAME_W-1] : 1'b0;
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_rx_data = rx_data_q;
  assign bus.spi_rx_done = rx_done_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: SPI master tasks, an event-queue model of
// expected frames/errors, and a per-cycle compare process.
module tb_spi_frame_slave;

  localparam int HALF = 5;  // clk cycles per SCLK phase (SCLK = clk/10)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_frame_slave_if #(.FRAME_W(32)) bus ();

  spi_frame_slave #(.FRAME_W(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] model_rx = 32'h0;
  int          checks = 0;
  int          passed = 0;
  int          done_seen = 0;
  int          err_seen = 0;
  int          cs_high_cnt = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle compare against the event model.
  always @(posedge clk) begin
    #2;
    if (bus.spi_cs_n) cs_high_cnt++;
    else cs_high_cnt = 0;
    if (rst_n && chk_en) begin
      if (bus.spi_rx_done || bus.frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'h0, bus.spi_rx_done, bus.frame_err}, 32'h0);
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          if (bus.spi_rx_done) begin
            check("done_kind", {31'h0, ev.is_err}, 32'h0);
            check("done_data", bus.spi_rx_data, ev.data);
            model_rx = ev.data;
            done_seen++;
          end else begin
            check("err_kind", {31'h0, ev.is_err}, 32'h1);
            check("err_rx_hold", bus.spi_rx_data, model_rx);
            err_seen++;
          end
        end
      end else begin
        check("rx_data_hold", bus.spi_rx_data, model_rx);
      end
      if (cs_high_cnt >= 4) check("miso_idle", {31'h0, bus.spi_miso}, 32'h0);
    end
  end

  // One CS_N window of nbits SCLK cycles; abort_at >= 0 applies reset after that many bits.
  task automatic frame(input logic [31:0] mosi_word, input int nbits,
                       input logic [31:0] tx_word, input int abort_at,
                       output logic [31:0] miso_word);
    bus.spi_tx_data = tx_word;
    bus.spi_cs_n = 1'b0;
    wait_clk(8);
    miso_word = 32'h0;
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        model_rx = 32'h0;
        wait_clk(3);
        check("rst_rx_data", bus.spi_rx_data, 32'h0);
        check("rst_rx_done", {31'h0, bus.spi_rx_done}, 32'h0);
        check("rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
        check("rst_miso", {31'h0, bus.spi_miso}, 32'h0);
        rst_n = 1'b1;
        wait_clk(4);
        return;
      end
      bus.spi_mosi = (i < 32) ? mosi_word[31-i] : i[0];
      wait_clk(HALF);
      if (i < 32) begin
        miso_word[31-i] = bus.spi_miso;
        check("miso_bit", {31'h0, bus.spi_miso}, {31'h0, tx_word[31-i]});
      end else begin
        check("miso_hold", {31'h0, bus.spi_miso}, 32'h0);
      end
      bus.spi_sclk = 1'b1;
      if (i == 31) exp_q.push_back('{1'b0, mosi_word});
      wait_clk(HALF);
      bus.spi_sclk = 1'b0;
    end
    wait_clk(HALF);
    bus.spi_cs_n = 1'b1;
    if (nbits >= 1 && nbits < 32) exp_q.push_back('{1'b1, 32'h0});
    wait_clk(4);
  endtask

  task automatic settle();
    wait_clk(20);
    check("events_drained", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    logic [31:0] m;
    int d0, e0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.spi_tx_data = 32'h0;
    wait_clk(4);
    check("init_rx_data", bus.spi_rx_data, 32'h0);
    check("init_rx_done", {31'h0, bus.spi_rx_done}, 32'h0);
    check("init_frame_err", {31'h0, bus.frame_err}, 32'h0);
    check("init_miso", {31'h0, bus.spi_miso}, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    wait_clk(4);

    // Write frame
    d0 = done_seen; e0 = err_seen;
    frame(32'h002001B2, 32, 32'h0, -1, m);
    settle();
    check("write_rx_data", bus.spi_rx_data, 32'h002001B2);
    check("write_done_cnt", 32'(done_seen - d0), 32'd1);
    check("write_err_cnt", 32'(err_seen - e0), 32'd0);

    // Read frame: response held before CS_N falls
    bus.spi_tx_data = 32'h000001B2;
    wait_clk(3);
    frame(32'h002001B2, 32, 32'h000001B2, -1, m);
    settle();
    check("read_miso_word", m, 32'h000001B2);
    check("read_miso_after", {31'h0, bus.spi_miso}, 32'h0);

    // Aborted frame after 10 bits
    d0 = done_seen; e0 = err_seen;
    frame(32'hFFFF0000, 10, 32'hFFFFFFFF, -1, m);
    settle();
    check("abort_rx_data", bus.spi_rx_data, 32'h002001B2);
    check("abort_err_cnt", 32'(err_seen - e0), 32'd1);
    check("abort_done_cnt", 32'(done_seen - d0), 32'd0);

    // Overclocked frame: 40 SCLK cycles
    d0 = done_seen;
    frame(32'hDEADBEEF, 40, 32'h12345678, -1, m);
    settle();
    check("over_rx_data", bus.spi_rx_data, 32'hDEADBEEF);
    check("over_done_cnt", 32'(done_seen - d0), 32'd1);
    check("over_miso_word", m, 32'h12345678);

    // Reset after 16 bits, then a full frame
    d0 = done_seen; e0 = err_seen;
    frame(32'h3C3C3C3C, 32, 32'h0F0F0F0F, 16, m);
    frame(32'hA5A5A5A5, 32, 32'h5A5A5A5A, -1, m);
    settle();
    check("rst_new_rx_data", bus.spi_rx_data, 32'hA5A5A5A5);
    check("rst_done_cnt", 32'(done_seen - d0), 32'd1);
    check("rst_err_cnt", 32'(err_seen - e0), 32'd0);

    // Back-to-back frames with a 4-clk CS_N gap
    d0 = done_seen;
    frame(32'h01000000, 32, 32'h00000000, -1, m);
    frame(32'h01080000, 32, 32'hCAFEF00D, -1, m);
    settle();
    check("b2b_rx_data", bus.spi_rx_data, 32'h01080000);
    check("b2b_done_cnt", 32'(done_seen - d0), 32'd2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
